// File: rtl/wb_mem_stage.sv
// MEM/WB segment: byte-lane data RAM with a debug port, W-side pipeline registers.
// Ports: clk, rst (sync, active high), en/clear segment control; port A
//   (A, WD, StoreM, LoadM, SizeM -> RD, LoadedBytesSelect, MisalignW, StallReq);
//   debug port B (A2, WD2, WE2 -> RD2); passthrough ResultM/RdM/RegWriteM/MemToRegM
//   -> *W. Define WB_MISALIGN_SPLIT_EN to split misaligned stores over two cycles.
module wb_mem_stage #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clear,
    input  logic [XLEN-1:0]              A,
    input  logic [XLEN-1:0]              WD,
    input  logic                         StoreM,
    input  logic                         LoadM,
    input  logic [1:0]                   SizeM,
    output logic [XLEN-1:0]              RD,
    output logic [$clog2(XLEN/8)-1:0]    LoadedBytesSelect,
    output logic                         MisalignW,
    output logic                         StallReq,
    input  logic [XLEN-1:0]              A2,
    input  logic [XLEN-1:0]              WD2,
    input  logic [XLEN/8-1:0]            WE2,
    output logic [XLEN-1:0]              RD2,
    input  logic [XLEN-1:0]              ResultM,
    output logic [XLEN-1:0]              ResultW,
    input  logic [4:0]                   RdM,
    output logic [4:0]                   RdW,
    input  logic [2:0]                   RegWriteM,
    output logic [2:0]                   RegWriteW,
    input  logic                         MemToRegM,
    output logic                         MemToRegW
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [OB-1:0]   off;
    logic [AW-1:0]   widx;
    logic [AW-1:0]   widx2;
    logic [4:0]      nbytes;
    logic [4:0]      span;
    logic            access;
    logic            illegal;
    logic            misaligned;
    logic [15:0]     lo_mask16;

    assign off        = A[OB-1:0];
    assign widx       = A[OB+AW-1:OB];
    assign widx2      = A2[OB+AW-1:OB];
    assign nbytes     = 5'd1 << SizeM;
    assign span       = 5'(off) + nbytes;
    assign access     = StoreM | LoadM;
    assign illegal    = (XLEN == 32) && (SizeM == 2'b11);
    assign misaligned = access && (span > 5'(NB));
    // Truncating the shifted mask to NB lanes also yields the low part
    // (lanes off..NB-1) of a store that crosses the word boundary.
    assign lo_mask16  = ((16'd1 << nbytes) - 16'd1) << off;

    logic            we_a;
    logic [AW-1:0]   wa_idx;
    logic [NB-1:0]   wa_mask;
    logic [XLEN-1:0] wa_data;
    logic            mis_flag;
    logic            unused_bits;

`ifdef WB_MISALIGN_SPLIT_EN
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_nx;
    logic [15:0] hi_mask16;
    logic [OB:0] rem;

    assign hi_mask16 = (16'd1 << (span - 5'(NB))) - 16'd1;
    assign rem       = (OB+1)'(NB) - (OB+1)'(off);

    // The hazard unit holds M while StallReq is up, so the SPLIT cycle
    // still sees the same A/WD/SizeM and can derive the high part from them.
    always_comb begin
        state_nx = state;
        StallReq = 1'b0;
        we_a     = 1'b0;
        wa_idx   = widx;
        wa_mask  = lo_mask16[NB-1:0];
        wa_data  = WD << {off, 3'b000};
        mis_flag = (access && illegal) || (misaligned && LoadM);
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (StoreM && !illegal) begin
                        we_a = 1'b1;
                        if (misaligned) begin
                            StallReq = 1'b1;
                            state_nx = SPLIT;
                        end
                    end
                end
                SPLIT: begin
                    we_a     = 1'b1;
                    wa_idx   = widx + AW'(1);
                    wa_mask  = hi_mask16[NB-1:0];
                    wa_data  = WD >> {rem, 3'b000};
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    assign unused_bits = ^{A[XLEN-1:OB+AW], A2[XLEN-1:OB+AW], A2[OB-1:0],
                           lo_mask16[15:NB], hi_mask16[15:NB]};
`else
    assign StallReq = 1'b0;

    always_comb begin
        we_a     = !rst && StoreM && !illegal && !misaligned;
        wa_idx   = widx;
        wa_mask  = lo_mask16[NB-1:0];
        wa_data  = WD << {off, 3'b000};
        mis_flag = (access && illegal) || misaligned;
    end

    assign unused_bits = ^{A[XLEN-1:OB+AW], A2[XLEN-1:OB+AW], A2[OB-1:0],
                           lo_mask16[15:NB]};
`endif

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] ram_q;

    // Read-before-write on both ports; clear never gates the write.
    always_ff @(posedge clk) begin
        ram_q <= mem[widx];
        RD2   <= mem[widx2];
        for (int i = 0; i < NB; i++) begin
            if (we_a && wa_mask[i])
                mem[wa_idx][8*i +: 8] <= wa_data[8*i +: 8];
            if (WE2[i])
                mem[widx2][8*i +: 8] <= WD2[8*i +: 8];
        end
    end

    logic            stall_q;
    logic            clear_q;
    logic [XLEN-1:0] rd_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            ResultW           <= '0;
            RdW               <= '0;
            RegWriteW         <= '0;
            MemToRegW         <= 1'b0;
            LoadedBytesSelect <= '0;
            MisalignW         <= 1'b0;
            clear_q           <= 1'b1;
            stall_q           <= 1'b0;
            rd_hold           <= '0;
        end else begin
            rd_hold <= RD;
            if (clear) begin
                ResultW           <= '0;
                RdW               <= '0;
                RegWriteW         <= '0;
                MemToRegW         <= 1'b0;
                LoadedBytesSelect <= '0;
                MisalignW         <= 1'b0;
                clear_q           <= 1'b1;
                stall_q           <= 1'b0;
            end else if (en && !StallReq) begin
                ResultW           <= ResultM;
                RdW               <= RdM;
                RegWriteW         <= RegWriteM;
                MemToRegW         <= MemToRegM;
                LoadedBytesSelect <= off;
                MisalignW         <= mis_flag;
                clear_q           <= 1'b0;
                stall_q           <= 1'b0;
            end else begin
                clear_q           <= 1'b0;
                stall_q           <= 1'b1;
            end
        end
    end

    // The RAM output moves every cycle, so a stalled WB replays what it showed.
    assign RD = clear_q ? '0 : (stall_q ? rd_hold : ram_q);

endmodule

// File: tb/tb_wb_mem_stage.sv
// Self-checking bench for wb_mem_stage (XLEN=32) against a byte-array model.
// Works with WB_MISALIGN_SPLIT_EN either defined or undefined.
module tb_wb_mem_stage;

    localparam int XLEN  = 32;
    localparam int NB    = 4;
    localparam int DEPTH = 4096;
    localparam int MEMB  = DEPTH * NB;

    logic        clk = 1'b0;
    logic        rst, en, clear;
    logic [31:0] A, WD;
    logic        StoreM, LoadM;
    logic [1:0]  SizeM;
    logic [31:0] RD;
    logic [1:0]  LoadedBytesSelect;
    logic        MisalignW, StallReq;
    logic [31:0] A2, WD2, RD2;
    logic [3:0]  WE2;
    logic [31:0] ResultM, ResultW;
    logic [4:0]  RdM, RdW;
    logic [2:0]  RegWriteM, RegWriteW;
    logic        MemToRegM, MemToRegW;

    always #5 clk = ~clk;

    wb_mem_stage #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .A(A), .WD(WD), .StoreM(StoreM), .LoadM(LoadM), .SizeM(SizeM),
        .RD(RD), .LoadedBytesSelect(LoadedBytesSelect),
        .MisalignW(MisalignW), .StallReq(StallReq),
        .A2(A2), .WD2(WD2), .WE2(WE2), .RD2(RD2),
        .ResultM(ResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegM(MemToRegM), .MemToRegW(MemToRegW)
    );

    logic [7:0]  mm [MEMB];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic [2:0]  e_rw;
    logic        e_m2r;

    function automatic logic [31:0] mword(int a);
        int b;
        b = (a % MEMB) & ~(NB - 1);
        return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    task automatic mstore(int a, int sz, logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++)
            mm[(a + i) % MEMB] = wd[8*i +: 8];
    endtask

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(logic st, logic ld, int sz, int a, logic [31:0] wd);
        StoreM    = st;
        LoadM     = ld;
        SizeM     = 2'(sz);
        A         = 32'(a);
        WD        = wd;
        ResultM   = $urandom;
        RdM       = 5'($urandom);
        RegWriteM = 3'($urandom);
        MemToRegM = 1'($urandom);
        e_res     = ResultM;
        e_rd      = RdM;
        e_rw      = RegWriteM;
        e_m2r     = MemToRegM;
        #1;
    endtask

    task automatic check_w(string tag);
        chk({tag, "_res"}, 64'(ResultW), 64'(e_res));
        chk({tag, "_rd"},  64'(RdW),     64'(e_rd));
        chk({tag, "_rw"},  64'(RegWriteW), 64'(e_rw));
        chk({tag, "_m2r"}, 64'(MemToRegW), 64'(e_m2r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w, a, sz, off, kind, wb;
        logic [31:0] d, held, e20, e24, rd2e;

        rst = 1'b1; en = 1'b1; clear = 1'b0;
        A = '0; WD = '0; StoreM = 1'b0; LoadM = 1'b0; SizeM = '0;
        A2 = '0; WD2 = '0; WE2 = '0;
        ResultM = '0; RdM = '0; RegWriteM = '0; MemToRegM = 1'b0;
        tick();
        tick();
        chk("rst_rd",    64'(RD), 64'(0));
        chk("rst_res",   64'(ResultW), 64'(0));
        chk("rst_rdw",   64'(RdW), 64'(0));
        chk("rst_rw",    64'(RegWriteW), 64'(0));
        chk("rst_m2r",   64'(MemToRegW), 64'(0));
        chk("rst_lbs",   64'(LoadedBytesSelect), 64'(0));
        chk("rst_mis",   64'(MisalignW), 64'(0));
        chk("rst_stall", 64'(StallReq), 64'(0));
        rst = 1'b0;

        // Preload words 0..127 through port B.
        for (int i = 0; i < 128; i++) begin
            A2  = 32'(i * 4);
            WD2 = $urandom;
            WE2 = 4'hF;
            mstore(i * 4, 2, WD2);
            tick();
        end
        WE2 = '0;
        for (int i = 0; i < 4; i++) begin
            w  = $urandom_range(0, 127);
            A2 = 32'(w * 4);
            tick();
            chk("rd2_pre", 64'(RD2), 64'(mword(w * 4)));
        end

        set_m(1'b1, 1'b0, 2, 32'h10, 32'hDEADBEEF);
        tick();
        mstore(32'h10, 2, 32'hDEADBEEF);
        check_w("st_word");
        set_m(1'b0, 1'b1, 2, 32'h10, '0);
        tick();
        chk("ld_word_rd",  64'(RD), 64'h0000_0000_DEAD_BEEF);
        chk("ld_word_mis", 64'(MisalignW), 64'(0));
        check_w("ld_word");

        set_m(1'b1, 1'b0, 0, 32'h13, 32'h0000_00AB);
        tick();
        mstore(32'h13, 0, 32'h0000_00AB);
        set_m(1'b0, 1'b1, 0, 32'h13, '0);
        tick();
        chk("ld_byte_rd",  64'(RD), 64'h0000_0000_ABAD_BEEF);
        chk("ld_byte_lbs", 64'(LoadedBytesSelect), 64'(3));
        set_m(1'b0, 1'b1, 2, 32'h10, '0);
        tick();
        chk("ld_w10_rd",  64'(RD), 64'(mword(32'h10)));
        chk("ld_w10_lbs", 64'(LoadedBytesSelect), 64'(0));

        // Random mix of aligned/misaligned loads and stores on words 0..63,
        // with concurrent port B traffic on words 64..127.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 3);
            w    = $urandom_range(0, 62);
            if (kind < 2) begin
                sz  = $urandom_range(0, 2);
                off = ($urandom_range(0, 3) >> sz) << sz;
            end else begin
                sz  = $urandom_range(1, 2);
                off = (sz == 1) ? 3 : $urandom_range(1, 3);
            end
            a    = w * 4 + off;
            d    = $urandom;
            wb   = $urandom_range(64, 127);
            A2   = 32'(wb * 4);
            WD2  = $urandom;
            WE2  = 4'($urandom);
            rd2e = mword(wb * 4);
            set_m(kind == 0 || kind == 3, kind == 1 || kind == 2, sz, a, d);
`ifdef WB_MISALIGN_SPLIT_EN
            if (kind == 3) chk("rnd_stall_hi", 64'(StallReq), 64'(1));
`else
            if (kind == 3) chk("rnd_stall_lo", 64'(StallReq), 64'(0));
`endif
            tick();
            chk("rnd_rd2", 64'(RD2), 64'(rd2e));
            for (int l = 0; l < NB; l++)
                if (WE2[l]) mm[wb * 4 + l] = WD2[8*l +: 8];
            WE2 = '0;
            if (kind == 3) begin
`ifdef WB_MISALIGN_SPLIT_EN
                chk("rnd_split_stall", 64'(StallReq), 64'(0));
                tick();
                mstore(a, sz, d);
                chk("rnd_split_mis", 64'(MisalignW), 64'(0));
`else
                chk("rnd_mst_mis", 64'(MisalignW), 64'(1));
`endif
            end else begin
                if (kind == 0) mstore(a, sz, d);
                if (kind != 0) begin
                    chk("rnd_ld_rd",  64'(RD), 64'(mword(a)));
                    chk("rnd_ld_lbs", 64'(LoadedBytesSelect), 64'(off));
                end
                chk("rnd_mis", 64'(MisalignW), 64'(kind == 2));
            end
            check_w("rnd");
        end

        // Misaligned word store 0x11223344 at 0x22.
        e20 = mword(32'h20);
        e24 = mword(32'h24);
        set_m(1'b1, 1'b0, 2, 32'h22, 32'h1122_3344);
`ifdef WB_MISALIGN_SPLIT_EN
        chk("ms_stall1", 64'(StallReq), 64'(1));
        tick();
        chk("ms_stall2", 64'(StallReq), 64'(0));
        tick();
        chk("ms_stall3", 64'(StallReq), 64'(0));
        chk("ms_mis", 64'(MisalignW), 64'(0));
        mstore(32'h22, 2, 32'h1122_3344);
        set_m(1'b0, 1'b1, 2, 32'h20, '0);
        tick();
        chk("ms_w20", 64'(RD), 64'(mword(32'h20)));
        chk("ms_w20_hi", 64'(RD[31:16]), 64'h3344);
        chk("ms_w20_lo", 64'(RD[15:0]), 64'(e20[15:0]));
        set_m(1'b0, 1'b1, 2, 32'h24, '0);
        tick();
        chk("ms_w24", 64'(RD), 64'(mword(32'h24)));
        chk("ms_w24_lo", 64'(RD[15:0]), 64'h1122);
        chk("ms_w24_hi", 64'(RD[31:16]), 64'(e24[31:16]));

        // Crossing the last word wraps the high part to word 0.
        set_m(1'b1, 1'b0, 2, (DEPTH - 1) * 4 + 2, 32'hA5C3_5A3C);
        tick();
        tick();
        mstore((DEPTH - 1) * 4 + 2, 2, 32'hA5C3_5A3C);
        set_m(1'b0, 1'b1, 2, 0, '0);
        tick();
        chk("wrap_w0", 64'(RD), 64'(mword(0)));
`else
        chk("ms_stall1", 64'(StallReq), 64'(0));
        tick();
        chk("ms_stall2", 64'(StallReq), 64'(0));
        chk("ms_mis", 64'(MisalignW), 64'(1));
        set_m(1'b0, 1'b1, 2, 32'h20, '0);
        tick();
        chk("ms_mis_clr", 64'(MisalignW), 64'(0));
        chk("ms_w20", 64'(RD), 64'(e20));
        set_m(1'b0, 1'b1, 2, 32'h24, '0);
        tick();
        chk("ms_w24", 64'(RD), 64'(e24));
`endif

        // Stall holds RD and W; clear zeroes them.
        set_m(1'b0, 1'b1, 2, 32'h10, '0);
        tick();
        held = mword(32'h10);
        chk("st_ld", 64'(RD), 64'(held));
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            A       = 32'($urandom_range(0, 63) * 4);
            ResultM = $urandom;
            tick();
            chk("stall_rd",  64'(RD), 64'(held));
            chk("stall_res", 64'(ResultW), 64'(e_res));
        end
        en    = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_rd",  64'(RD), 64'(0));
        chk("clr_res", 64'(ResultW), 64'(0));
        chk("clr_rdw", 64'(RdW), 64'(0));
        set_m(1'b0, 1'b1, 2, 32'h10, '0);
        tick();
        chk("post_clr_rd", 64'(RD), 64'(mword(32'h10)));

`ifdef WB_MISALIGN_SPLIT_EN
        // Reset during SPLIT drops the high part.
        set_m(1'b1, 1'b0, 2, 32'h32, 32'hCAFE_F00D);
        chk("rs_stall", 64'(StallReq), 64'(1));
        tick();
        mm[32'h32] = 8'h0D;
        mm[32'h33] = 8'hF0;
        rst = 1'b1;
        #1;
        chk("rs_stall_rst", 64'(StallReq), 64'(0));
        tick();
        chk("rs_rd",  64'(RD), 64'(0));
        chk("rs_res", 64'(ResultW), 64'(0));
        chk("rs_mis", 64'(MisalignW), 64'(0));
        rst = 1'b0;
        set_m(1'b0, 1'b1, 2, 32'h34, '0);
        tick();
        chk("rs_w34", 64'(RD), 64'(mword(32'h34)));
        set_m(1'b0, 1'b1, 2, 32'h30, '0);
        tick();
        chk("rs_w30", 64'(RD), 64'(mword(32'h30)));
        set_m(1'b1, 1'b0, 1, 32'h37, 32'h0000_BEEF);
        chk("rs_idle", 64'(StallReq), 64'(1));
        tick();
        tick();
        mstore(32'h37, 1, 32'h0000_BEEF);
        set_m(1'b0, 1'b1, 2, 32'h38, '0);
        tick();
        chk("rs_w38", 64'(RD), 64'(mword(32'h38)));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
